// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch unit: the default
// program loaded at reset, the NOP word and the fetch-unit FSM states.
package imem_pkg;

   localparam int DEFAULT_PROG_LEN = 6;

   // Word 0 of the default program sits in the most significant byte.
   localparam logic [DEFAULT_PROG_LEN*8-1:0] DEFAULT_PROG =
      {8'h15, 8'h51, 8'h2a, 8'hc5, 8'h6b, 8'h0d};

   localparam logic [7:0] NOP_INSTR = 8'h00;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Returns word idx of the default program, or NOP past its end.
   function automatic logic [7:0] default_prog_word(input int idx);
      logic [7:0] word;
      word = NOP_INSTR;
      if ((idx >= 0) && (idx < DEFAULT_PROG_LEN)) begin
         word = DEFAULT_PROG[(DEFAULT_PROG_LEN - 1 - idx) * 8 +: 8];
      end
      return word;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x WIDTH word array, one synchronous write port and one registered
// read port. A read and a write to the same address in the same cycle
// return the old word (read-before-write). The read register has no reset
// so the array maps onto block RAM.
module imem_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port; both nonblocking, so the read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory fetch unit: reset-time loader of the default program,
// program-load write port, and a registered fetch port (1-cycle latency)
// with valid/ready handshake and downstream stall.
// Optional build macro IMEM_FETCH_CNT_EN adds a saturating 16-bit count
// of accepted fetches on output fetch_cnt.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_req,
   input  logic [ADDR_W-1:0]  fetch_addr,
   output logic               fetch_ready,
   input  logic               stall,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_code,
   output logic               addr_err,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic               init_done
`ifdef IMEM_FETCH_CNT_EN
   ,
   output logic [15:0]        fetch_cnt
`endif
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(DEPTH - 1);

   state_e              state_reg, state_next;
   logic [RAM_AW-1:0]   cnt_reg, cnt_next;
   logic                valid_reg, valid_next;
   logic                err_reg, err_next;
   // Forces instr_code to zero after reset and after an out-of-range fetch,
   // since the RAM read register itself is never reset.
   logic                zero_reg, zero_next;

   logic                accept;
   logic                fetch_in_range;
   logic                prog_in_range;

   logic                ram_we;
   logic [RAM_AW-1:0]   ram_waddr;
   logic [INSTR_W-1:0]  ram_wdata;
   logic                ram_re;
   logic [RAM_AW-1:0]   ram_rdata_unused_guard;
   logic [INSTR_W-1:0]  ram_rdata;

   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
   assign prog_in_range  = ({1'b0, prog_addr} < DEPTH_L);

   assign init_done   = (state_reg == RUN);
   assign fetch_ready = (state_reg == RUN) && !(valid_reg && stall);
   assign accept      = fetch_req && fetch_ready;

   assign instr_valid = valid_reg;
   assign addr_err    = err_reg;
   assign instr_code  = zero_reg ? '0 : ram_rdata;

   assign ram_rdata_unused_guard = fetch_addr[RAM_AW-1:0];

   // State, init counter and handshake registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= INIT;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         zero_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
         zero_reg  <= zero_next;
      end
   end

   // Next-state, handshake and RAM port control.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      valid_next = valid_reg;
      err_next   = err_reg;
      zero_next  = zero_reg;
      ram_we     = 1'b0;
      ram_waddr  = prog_addr[RAM_AW-1:0];
      ram_wdata  = prog_data;
      ram_re     = 1'b0;

      case (state_reg)
         INIT: begin
            // Load one default-program word per cycle; fetches and
            // program writes are ignored until the array is filled.
            ram_we    = 1'b1;
            ram_waddr = cnt_reg;
            if (int'(cnt_reg) < DEFAULT_PROG_LEN) begin
               ram_wdata = INSTR_W'(default_prog_word(int'(cnt_reg)));
            end else begin
               ram_wdata = INSTR_W'(NOP_INSTR);
            end
            cnt_next   = cnt_reg + 1'b1;
            valid_next = 1'b0;
            if (cnt_reg == LAST_IDX) begin
               state_next = RUN;
            end
         end
         RUN: begin
            ram_we = prog_we && prog_in_range;
            if (accept) begin
               valid_next = 1'b1;
               err_next   = !fetch_in_range;
               zero_next  = !fetch_in_range;
               ram_re     = fetch_in_range;
            end else if (!(valid_reg && stall)) begin
               valid_next = 1'b0;
            end
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   imem_ram #(
      .WIDTH (INSTR_W),
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_rdata_unused_guard),
      .rdata (ram_rdata)
   );

`ifdef IMEM_FETCH_CNT_EN
   logic [15:0] fetch_cnt_reg;

   // Saturating count of accepted fetches, cleared while loading.
   always_ff @(posedge clk) begin
      if (reset || (state_reg == INIT)) begin
         fetch_cnt_reg <= '0;
      end else if (accept && (fetch_cnt_reg != 16'hFFFF)) begin
         fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule
